// File: rtl/stream_pkg.sv
// Shared types and helpers for the stream master FIFO slice.
package stream_pkg;

   localparam int DROP_W = 16;

   typedef enum logic {PASS_ALL, CHANGE_ONLY} fwd_mode_t;

   // Width of an index into n entries, never below one bit.
   function automatic int clog2_safe(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// Power-of-two synchronous FIFO; full/empty derive from an occupancy count.
module sync_fifo
   import stream_pkg::*;
#(
   parameter int DATA_W = 2,
   parameter int DEPTH  = 4,
   localparam int PTR_W = clog2_safe(DEPTH),
   localparam int LVL_W = $clog2(DEPTH + 1)
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              push,
   input  logic              pop,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata,
   output logic              full,
   output logic              empty,
   output logic [LVL_W-1:0]  level
);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         level <= level + LVL_W'(push) - LVL_W'(pop);
      end
   end

   // NOTE: storage is deliberately not reset; level gates every read, so stale entries are never seen.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= wdata;
   end

   assign rdata = mem[rd_ptr];
   assign full  = (level == LVL_W'(DEPTH));
   assign empty = (level == '0);

endmodule

// File: rtl/stream_master_fifo.sv
// Valid/ready stream master: optional change-detect filter, FIFO, show-ahead output register.
module stream_master_fifo #(
   parameter int DATA_W      = 2,
   parameter int DEPTH       = 4,
   parameter int CHANGE_ONLY = 0
) (
   input  logic                          clk,
   input  logic                          rstn,
   input  logic [DATA_W-1:0]             in_data,
   input  logic                          in_valid,
   output logic                          in_ready,
   output logic [DATA_W-1:0]             out_data,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [$clog2(DEPTH+1)-1:0]    level,
   output logic [stream_pkg::DROP_W-1:0] dropped
);
   import stream_pkg::*;

   localparam int        LVL_W = $clog2(DEPTH + 1);
   localparam fwd_mode_t MODE  = (CHANGE_ONLY != 0) ? stream_pkg::CHANGE_ONLY : PASS_ALL;

   logic [DATA_W-1:0] fifo_rdata;
   logic [DATA_W-1:0] last_sent;
   logic              fifo_full;
   logic              fifo_empty;
   logic              first_flag;
   logic              accept;
   logic              keep;
   logic              push;
   logic              pop;
   logic [LVL_W-1:0]  level_next;

   assign accept = in_valid && in_ready;
   assign keep   = (MODE == PASS_ALL) || first_flag || (in_data != last_sent);
   assign push   = accept && keep && !fifo_full;
   // Head moves into the output register whenever that register is free or being consumed.
   assign pop    = !fifo_empty && (!out_valid || out_ready);
   assign level_next = level + LVL_W'(push) - LVL_W'(pop);

   sync_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rstn  (rstn),
      .push  (push),
      .pop   (pop),
      .wdata (in_data),
      .rdata (fifo_rdata),
      .full  (fifo_full),
      .empty (fifo_empty),
      .level (level)
   );

   // in_ready is registered from next-cycle occupancy, so it never depends on out_ready combinationally.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         in_ready   <= 1'b0;
         out_valid  <= 1'b0;
         out_data   <= '0;
         first_flag <= 1'b1;
         last_sent  <= '0;
         dropped    <= '0;
      end else begin
         in_ready <= (level_next != LVL_W'(DEPTH));
         if (pop) begin
            out_data  <= fifo_rdata;
            out_valid <= 1'b1;
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end
         if (push) begin
            last_sent  <= in_data;
            first_flag <= 1'b0;
         end
         if (accept && !keep && (dropped != '1)) dropped <= dropped + DROP_W'(1);
      end
   end

endmodule

// File: tb/tb_stream_master_fifo.sv
// Bench: pass-all (8-bit) and change-only (2-bit) instances on one stimulus, queue model plus scoreboard.
module tb_stream_master_fifo;

   logic       clk = 1'b0;
   logic       rstn = 1'b0;
   logic       in_valid = 1'b0;
   logic       out_ready = 1'b0;
   logic [7:0] in_data = 8'h00;

   logic       ir_p, ov_p, ir_c, ov_c;
   logic [7:0] od_p;
   logic [1:0] od_c;
   logic [2:0] lv_p, lv_c;
   logic [15:0] dr_p, dr_c;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   stream_master_fifo #(.DATA_W(8), .DEPTH(4), .CHANGE_ONLY(0)) u_dut (
      .clk(clk), .rstn(rstn), .in_data(in_data), .in_valid(in_valid), .in_ready(ir_p),
      .out_data(od_p), .out_valid(ov_p), .out_ready(out_ready), .level(lv_p), .dropped(dr_p)
   );

   stream_master_fifo #(.DATA_W(2), .DEPTH(4), .CHANGE_ONLY(1)) u_chg (
      .clk(clk), .rstn(rstn), .in_data(in_data[1:0]), .in_valid(in_valid), .in_ready(ir_c),
      .out_data(od_c), .out_valid(ov_c), .out_ready(out_ready), .level(lv_c), .dropped(dr_c)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(negedge clk);
   endtask

   // Behavioural model: index 0 = pass-all, 1 = change-only. Queue holds stored entries.
   logic [7:0]  m_q [2][$];
   bit          m_ir [2];
   bit          m_ov [2];
   bit          m_first [2];
   logic [7:0]  m_od [2];
   logic [7:0]  m_last [2];
   int unsigned m_drop [2];

   always @(posedge clk) begin
      logic [7:0] d;
      bit         acc;
      for (int k = 0; k < 2; k++) begin
         d = in_data & ((k == 1) ? 8'h03 : 8'hFF);
         if (!rstn) begin
            m_q[k].delete();
            m_ir[k] = 0; m_ov[k] = 0; m_od[k] = 8'h00;
            m_first[k] = 1; m_last[k] = 8'h00; m_drop[k] = 0;
         end else begin
            acc = in_valid && m_ir[k];
            // Output slot refills from what was stored before this edge.
            if ((!m_ov[k] || out_ready) && m_q[k].size() > 0) begin
               m_od[k] = m_q[k].pop_front();
               m_ov[k] = 1;
            end else if (out_ready) begin
               m_ov[k] = 0;
            end
            if (acc) begin
               if (k == 0 || m_first[k] || d != m_last[k]) begin
                  m_q[k].push_back(d);
                  m_last[k]  = d;
                  m_first[k] = 0;
               end else if (m_drop[k] < 65535) begin
                  m_drop[k]++;
               end
            end
            m_ir[k] = (m_q[k].size() < 4);
         end
      end
   end

   // Per-cycle compare against the model, plus an end-to-end transaction scoreboard.
   logic [7:0] sb [2][$];
   bit         sb_first [2];
   logic [7:0] sb_last [2];
   bit         p_ir [2];
   bit         p_ov [2];
   logic [7:0] p_od [2];

   always @(posedge clk) begin
      logic        a_ir, a_ov;
      logic [7:0]  a_od, d, want;
      logic [2:0]  a_lv;
      logic [15:0] a_dr;
      #1;
      for (int k = 0; k < 2; k++) begin
         a_ir = (k == 0) ? ir_p : ir_c;
         a_ov = (k == 0) ? ov_p : ov_c;
         a_od = (k == 0) ? od_p : {6'b0, od_c};
         a_lv = (k == 0) ? lv_p : lv_c;
         a_dr = (k == 0) ? dr_p : dr_c;
         check($sformatf("in_ready[%0d]", k), 32'(a_ir), 32'(m_ir[k]));
         check($sformatf("out_valid[%0d]", k), 32'(a_ov), 32'(m_ov[k]));
         if (m_ov[k]) check($sformatf("out_data[%0d]", k), 32'(a_od), 32'(m_od[k]));
         check($sformatf("level[%0d]", k), 32'(a_lv), m_q[k].size());
         check($sformatf("dropped[%0d]", k), 32'(a_dr), m_drop[k]);
         if (!rstn) begin
            sb[k].delete();
            sb_first[k] = 1;
            sb_last[k]  = 8'h00;
         end else begin
            if (p_ov[k] && out_ready) begin
               check($sformatf("sb_pending[%0d]", k), 32'(sb[k].size() > 0), 32'd1);
               if (sb[k].size() > 0) begin
                  want = sb[k].pop_front();
                  check($sformatf("sb_data[%0d]", k), 32'(p_od[k]), 32'(want));
               end
            end
            if (p_ir[k] && in_valid) begin
               d = in_data & ((k == 1) ? 8'h03 : 8'hFF);
               if (k == 0 || sb_first[k] || d != sb_last[k]) begin
                  sb[k].push_back(d);
                  sb_last[k]  = d;
                  sb_first[k] = 0;
               end
            end
         end
         p_ir[k] = a_ir;
         p_ov[k] = a_ov;
         p_od[k] = a_od;
      end
   end

   logic [7:0] got [$];
   int         gcyc [$];
   int         acc_n;
   bit         bp_acc;
   logic [7:0] bp_vals [6] = '{8'd1, 8'd2, 8'd3, 8'd0, 8'd1, 8'd2};
   logic [7:0] bp_exp  [6] = '{8'd1, 8'd2, 8'd3, 8'd0, 8'd1, 8'd2};
   logic [7:0] ch_vals [6] = '{8'd3, 8'd3, 8'd3, 8'd1, 8'd1, 8'd3};
   logic [7:0] ch_exp  [3] = '{8'd3, 8'd1, 8'd3};
   logic [7:0] mr_vals [4] = '{8'd1, 8'd2, 8'd3, 8'd2};

   initial begin
      // Reset state
      step(); step();
      check("rst_in_ready", 32'(ir_p), 32'd0);
      check("rst_out_valid", 32'(ov_p), 32'd0);
      check("rst_out_data", 32'(od_p), 32'd0);
      check("rst_level", 32'(lv_p), 32'd0);
      check("rst_dropped", 32'(dr_c), 32'd0);
      rstn = 1'b1;
      step();
      check("post_rst_in_ready", 32'(ir_p), 32'd1);

      // Single beat: one-cycle latency through the FIFO into the output register
      in_data = 8'h02; in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      check("one_level_after_accept", 32'(lv_p), 32'd1);
      check("one_not_yet_valid", 32'(ov_p), 32'd0);
      step();
      check("one_out_valid", 32'(ov_p), 32'd1);
      check("one_out_data", 32'(od_p), 32'h02);
      check("one_chg_out_data", 32'(od_c), 32'h2);
      check("one_level_zero", 32'(lv_p), 32'd0);
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      check("one_consumed", 32'(ov_p), 32'd0);

      // Backpressure: fill FIFO plus output register, then pop at full
      acc_n = 0;
      for (int i = 0; i < 6; i++) begin
         in_data = bp_vals[i]; in_valid = 1'b1;
         if (ir_p) acc_n++;
         step();
      end
      check("bp_accepted", acc_n, 32'd5);
      check("bp_in_ready_low", 32'(ir_p), 32'd0);
      check("bp_level_full", 32'(lv_p), 32'd4);
      step();
      check("bp_hold_data", 32'(od_p), 32'd1);
      check("bp_hold_valid", 32'(ov_p), 32'd1);
      out_ready = 1'b1;
      got.delete();
      for (int c = 0; c < 16; c++) begin
         if (ov_p) got.push_back(od_p);
         bp_acc = in_valid && ir_p;
         step();
         if (c == 0) begin
            check("bp_reassert", 32'(ir_p), 32'd1);
            check("bp_level_after_pop", 32'(lv_p), 32'd3);
         end
         if (bp_acc) in_valid = 1'b0;
      end
      check("bp_drain_count", got.size(), 32'd6);
      for (int i = 0; i < 6 && i < got.size(); i++)
         check($sformatf("bp_drain_%0d", i), 32'(got[i]), 32'(bp_exp[i]));

      // Streaming: one beat per cycle, no gaps
      got.delete(); gcyc.delete();
      for (int c = 0; c < 40; c++) begin
         if (c < 32) begin
            in_data = 8'h40 + 8'(c); in_valid = 1'b1;
            check("st_in_ready", 32'(ir_p), 32'd1);
         end else begin
            in_valid = 1'b0;
         end
         if (ov_p) begin got.push_back(od_p); gcyc.push_back(c); end
         step();
         check("st_level_le1", 32'(lv_p <= 3'd1), 32'd1);
      end
      check("st_count", got.size(), 32'd32);
      if (gcyc.size() > 0) check("st_latency", gcyc[0], 32'd2);
      for (int i = 0; i < got.size(); i++) begin
         check($sformatf("st_data_%0d", i), 32'(got[i]), 32'h40 + i);
         check($sformatf("st_gap_%0d", i), gcyc[i], gcyc[0] + i);
      end

      // Change-only filtering after a fresh reset
      rstn = 1'b0; step(); rstn = 1'b1; step();
      got.delete();
      for (int c = 0; c < 14; c++) begin
         if (c < 6) begin in_data = ch_vals[c]; in_valid = 1'b1; end
         else in_valid = 1'b0;
         if (ov_c) got.push_back({6'b0, od_c});
         step();
      end
      check("ch_count", got.size(), 32'd3);
      for (int i = 0; i < 3 && i < got.size(); i++)
         check($sformatf("ch_data_%0d", i), 32'(got[i]), 32'(ch_exp[i]));
      check("ch_dropped", 32'(dr_c), 32'd3);
      check("ch_model_dropped", m_drop[1], 32'd3);
      check("ch_pass_dropped", 32'(dr_p), 32'd0);

      // Reset mid-transfer
      out_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         in_data = mr_vals[i]; in_valid = 1'b1;
         step();
      end
      in_valid = 1'b0;
      check("mr_level_pre", 32'(lv_p), 32'd3);
      check("mr_valid_pre", 32'(ov_p), 32'd1);
      rstn = 1'b0;
      step();
      check("mr_valid_cleared", 32'(ov_p), 32'd0);
      check("mr_level_cleared", 32'(lv_p), 32'd0);
      check("mr_chg_level_cleared", 32'(lv_c), 32'd0);
      check("mr_in_ready_low", 32'(ir_p), 32'd0);
      rstn = 1'b1;
      step();
      check("mr_in_ready_back", 32'(ir_c), 32'd1);
      in_data = 8'h02; in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      step();
      check("mr_first_fwd_valid", 32'(ov_c), 32'd1);
      check("mr_first_fwd_data", 32'(od_c), 32'h2);
      check("mr_first_fwd_dropped", 32'(dr_c), 32'd0);
      out_ready = 1'b1;
      step(); step();

      // Randomised valid/ready traffic, then drain
      for (int c = 0; c < 150; c++) begin
         in_valid  = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 2) != 0);
         in_data   = 8'($urandom_range(0, 5));
         step();
      end
      in_valid = 1'b0; out_ready = 1'b1;
      for (int c = 0; c < 10; c++) step();
      check("rnd_sb_empty_pass", sb[0].size(), 32'd0);
      check("rnd_sb_empty_chg", sb[1].size(), 32'd0);
      check("rnd_level_end", 32'(lv_p), 32'd0);
      check("rnd_valid_end", 32'(ov_c), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
